mem_arbiter: RTL and testbench

- Shares the single-port 256x16 data memory between two requesters: port A (CPU datapath) and port B (loader/DMA).
- Serialises accesses and drives the memory's memWR/dataAddr/inData, which it writes on negedge clk; outData is read combinationally.
- Returns read data and a one-cycle ack to the served requester.
- Selectable round-robin or fixed-A priority, with a starvation guard for B.

---
 rtl/mem_arbiter.sv | 170 +++++++++++++++++
 tb/tb_mem_arbiter.sv | 345 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_arbiter.sv
// mem_arbiter
//   Shares one single-port 256x16 data memory between two requesters:
//   port A (CPU datapath) and port B (loader/DMA). Accesses are serialised
//   through a small FSM: IDLE -> SERVE_x -> ACK_x -> IDLE, so every
//   transaction takes three cycles. The memory itself writes on the falling
//   edge, so the write strobe driven during SERVE_x lands mid-cycle. Read
//   data comes back combinationally and is captured at the end of SERVE_x.
//
// Parameters
//   PRIO_MODE  0 = round-robin between A and B, 1 = A has fixed priority
//   MAX_WAIT   fixed-priority mode only: once B has waited this many cycles
//              with its request high, B wins the next contested arbitration
//
// Ports
//   clk, rst                 clock and synchronous active-high reset
//   a_req/a_we/a_addr/a_wdata   port A request (held until a_ack)
//   a_ack, a_rdata           one-cycle completion pulse, captured read data
//   b_*                      same set for port B
//   mem_wr/mem_addr/mem_wdata   memory write strobe, address, write data
//   mem_rdata                memory read data (combinational from memory)
//   busy                     high whenever a transaction is in flight
module mem_arbiter #(
  parameter int PRIO_MODE = 0,
  parameter int MAX_WAIT  = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        a_req,
  input  logic        a_we,
  input  logic [7:0]  a_addr,
  input  logic [15:0] a_wdata,
  output logic        a_ack,
  output logic [15:0] a_rdata,
  input  logic        b_req,
  input  logic        b_we,
  input  logic [7:0]  b_addr,
  input  logic [15:0] b_wdata,
  output logic        b_ack,
  output logic [15:0] b_rdata,
  output logic        mem_wr,
  output logic [7:0]  mem_addr,
  output logic [15:0] mem_wdata,
  input  logic [15:0] mem_rdata,
  output logic        busy
);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    SERVE_A = 3'd1,
    SERVE_B = 3'd2,
    ACK_A   = 3'd3,
    ACK_B   = 3'd4
  } state_t;

  localparam logic [7:0] MAX_WAIT_CNT = 8'(MAX_WAIT);

  state_t      state_reg;
  logic        last_grant_reg;   // 0 = A was served last, 1 = B
  logic [7:0]  wait_cnt_reg;     // cycles B has been kept waiting
  logic        a_ack_reg;
  logic        b_ack_reg;
  logic [15:0] a_rdata_reg;
  logic [15:0] b_rdata_reg;
  logic        pick_b;

  assign a_ack   = a_ack_reg;
  assign b_ack   = b_ack_reg;
  assign a_rdata = a_rdata_reg;
  assign b_rdata = b_rdata_reg;
  assign busy    = (state_reg != IDLE);

  // Arbitration decision, only consumed in IDLE. A lone request always
  // wins; a tie goes to the port not served last (round-robin) or to A
  // unless B has waited long enough (fixed priority).
  always_comb begin
    pick_b = 1'b0;
    if (a_req && b_req) begin
      if (PRIO_MODE == 0) begin
        pick_b = ~last_grant_reg;
      end else begin
        pick_b = (wait_cnt_reg >= MAX_WAIT_CNT);
      end
    end else begin
      pick_b = b_req;
    end
  end

  // Memory bus is driven only while serving. The write strobe is gated by
  // rst so a reset landing on a SERVE cycle can never corrupt memory.
  always_comb begin
    mem_wr    = 1'b0;
    mem_addr  = 8'h00;
    mem_wdata = 16'h0000;
    case (state_reg)
      SERVE_A: begin
        mem_wr    = a_we & ~rst;
        mem_addr  = a_addr;
        mem_wdata = a_wdata;
      end
      SERVE_B: begin
        mem_wr    = b_we & ~rst;
        mem_addr  = b_addr;
        mem_wdata = b_wdata;
      end
      default: begin
        mem_wr    = 1'b0;
        mem_addr  = 8'h00;
        mem_wdata = 16'h0000;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_reg      <= IDLE;
      last_grant_reg <= 1'b1;    // pretend B went last so A wins the first tie
      wait_cnt_reg   <= 8'h00;
      a_ack_reg      <= 1'b0;
      b_ack_reg      <= 1'b0;
      a_rdata_reg    <= 16'h0000;
      b_rdata_reg    <= 16'h0000;
    end else begin
      // Starvation counter: only meaningful with fixed priority. It runs
      // while B is pending and not being handled, and saturates.
      if (PRIO_MODE == 0 || !b_req || state_reg == SERVE_B || state_reg == ACK_B) begin
        wait_cnt_reg <= 8'h00;
      end else if (wait_cnt_reg != 8'hFF) begin
        wait_cnt_reg <= wait_cnt_reg + 8'd1;
      end

      case (state_reg)
        IDLE: begin
          if (a_req || b_req) begin
            state_reg <= pick_b ? SERVE_B : SERVE_A;
          end
        end
        SERVE_A: begin
          if (!a_we) begin
            a_rdata_reg <= mem_rdata;
          end
          a_ack_reg      <= 1'b1;
          last_grant_reg <= 1'b0;
          state_reg      <= ACK_A;
        end
        SERVE_B: begin
          if (!b_we) begin
            b_rdata_reg <= mem_rdata;
          end
          b_ack_reg      <= 1'b1;
          last_grant_reg <= 1'b1;
          state_reg      <= ACK_B;
        end
        // The ACK cycle ignores requests, so a requester still holding req
        // is not served twice for the same handshake.
        ACK_A: begin
          a_ack_reg <= 1'b0;
          state_reg <= IDLE;
        end
        ACK_B: begin
          b_ack_reg <= 1'b0;
          state_reg <= IDLE;
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Testbench for mem_arbiter. Two instances share one stimulus stream:
// instance 0 is round-robin, instance 1 is fixed priority with MAX_WAIT = 4.
// Each instance has its own behavioural memory (written on negedge) and a
// transaction-level reference model; every cycle all outputs of both
// instances are compared against the model. Directed literal checks pin the
// expected behaviour of specific scenarios.
module tb_mem_arbiter;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic        rst;
  logic        a_req, a_we, b_req, b_we;
  logic [7:0]  a_addr, b_addr;
  logic [15:0] a_wdata, b_wdata;

  logic [1:0]  a_ack_d, b_ack_d, mem_wr_d, busy_d;
  logic [15:0] a_rdata_d [2];
  logic [15:0] b_rdata_d [2];
  logic [15:0] mem_wdata_d [2];
  logic [15:0] mem_rdata_d [2];
  logic [7:0]  mem_addr_d [2];

  int n_tests = 0;
  int n_fail  = 0;
  int cyc     = 0;

  // ack log entries: cycle*2 + port (0 = A, 1 = B)
  int log0[$];
  int log1[$];

  for (genvar gi = 0; gi < 2; gi++) begin : g_dut
    logic [15:0] mem [256] = '{default: 16'h0000};

    always @(negedge clk) begin
      if (mem_wr_d[gi]) mem[mem_addr_d[gi]] <= mem_wdata_d[gi];
    end
    assign mem_rdata_d[gi] = mem[mem_addr_d[gi]];

    mem_arbiter #(
      .PRIO_MODE (gi),
      .MAX_WAIT  ((gi == 1) ? 4 : 8)
    ) u_dut (
      .clk       (clk),
      .rst       (rst),
      .a_req     (a_req),
      .a_we      (a_we),
      .a_addr    (a_addr),
      .a_wdata   (a_wdata),
      .a_ack     (a_ack_d[gi]),
      .a_rdata   (a_rdata_d[gi]),
      .b_req     (b_req),
      .b_we      (b_we),
      .b_addr    (b_addr),
      .b_wdata   (b_wdata),
      .b_ack     (b_ack_d[gi]),
      .b_rdata   (b_rdata_d[gi]),
      .mem_wr    (mem_wr_d[gi]),
      .mem_addr  (mem_addr_d[gi]),
      .mem_wdata (mem_wdata_d[gi]),
      .mem_rdata (mem_rdata_d[gi]),
      .busy      (busy_d[gi])
    );
  end

  // ---------------- reference model ----------------
  // phase: 0 = no transaction, 1 = memory access cycle, 2 = acknowledge cycle
  int          m_phase [2];
  int          m_port  [2];
  int          m_last  [2];
  int          m_wait  [2];
  logic        m_aack  [2];
  logic        m_back  [2];
  logic [15:0] m_ard   [2];
  logic [15:0] m_brd   [2];
  logic [15:0] ref_mem [2][256];

  function automatic logic we_of(int p);
    return (p == 1) ? b_we : a_we;
  endfunction
  function automatic logic [7:0] addr_of(int p);
    return (p == 1) ? b_addr : a_addr;
  endfunction
  function automatic logic [15:0] wdata_of(int p);
    return (p == 1) ? b_wdata : a_wdata;
  endfunction

  task automatic chk(input string nm, input int inst, input logic [15:0] act, input logic [15:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s dut%0d cyc=%0d got=%h expected=%h", nm, inst, cyc, act, exp);
    end
  endtask

  task automatic model_reset(input int i);
    m_phase[i] = 0;
    m_port[i]  = 0;
    m_last[i]  = 1;
    m_wait[i]  = 0;
    m_aack[i]  = 1'b0;
    m_back[i]  = 1'b0;
    m_ard[i]   = 16'h0000;
    m_brd[i]   = 16'h0000;
  endtask

  task automatic model_step();
    for (int i = 0; i < 2; i++) begin
      int         g;
      int         nw;
      logic [7:0] ad;
      ad = addr_of(m_port[i]);
      // a write in the access cycle lands unless reset covers that cycle
      if (m_phase[i] == 1 && !rst && we_of(m_port[i])) ref_mem[i][ad] = wdata_of(m_port[i]);
      if (rst) begin
        model_reset(i);
      end else begin
        nw = m_wait[i];
        if (i == 1) begin
          if (!b_req || (m_phase[i] != 0 && m_port[i] == 1)) nw = 0;
          else if (nw < 255) nw = nw + 1;
        end
        if (m_phase[i] == 0) begin
          if (a_req || b_req) begin
            if (a_req && b_req) begin
              if (i == 0) g = (m_last[i] == 0) ? 1 : 0;
              else        g = (m_wait[i] >= 4) ? 1 : 0;
            end else begin
              g = b_req ? 1 : 0;
            end
            m_port[i]  = g;
            m_phase[i] = 1;
          end
        end else if (m_phase[i] == 1) begin
          if (!we_of(m_port[i])) begin
            if (m_port[i] == 1) m_brd[i] = ref_mem[i][ad];
            else                m_ard[i] = ref_mem[i][ad];
          end
          if (m_port[i] == 1) m_back[i] = 1'b1;
          else                m_aack[i] = 1'b1;
          m_last[i]  = m_port[i];
          m_phase[i] = 2;
        end else begin
          m_aack[i]  = 1'b0;
          m_back[i]  = 1'b0;
          m_phase[i] = 0;
        end
        m_wait[i] = nw;
      end
    end
  endtask

  task automatic compare_all();
    for (int i = 0; i < 2; i++) begin
      logic        ewr;
      logic [7:0]  ead;
      logic [15:0] ewd;
      ewr = 1'b0;
      ead = 8'h00;
      ewd = 16'h0000;
      if (m_phase[i] == 1) begin
        ewr = we_of(m_port[i]) & ~rst;
        ead = addr_of(m_port[i]);
        ewd = wdata_of(m_port[i]);
      end
      chk("a_ack",     i, 16'(a_ack_d[i]),  16'(m_aack[i]));
      chk("b_ack",     i, 16'(b_ack_d[i]),  16'(m_back[i]));
      chk("a_rdata",   i, a_rdata_d[i],     m_ard[i]);
      chk("b_rdata",   i, b_rdata_d[i],     m_brd[i]);
      chk("mem_wr",    i, 16'(mem_wr_d[i]), 16'(ewr));
      chk("mem_addr",  i, 16'(mem_addr_d[i]), 16'(ead));
      chk("mem_wdata", i, mem_wdata_d[i],   ewd);
      chk("busy",      i, 16'(busy_d[i]),   16'(m_phase[i] != 0));
      if (a_ack_d[i]) begin
        if (i == 0) log0.push_back(cyc * 2); else log1.push_back(cyc * 2);
      end
      if (b_ack_d[i]) begin
        if (i == 0) log0.push_back(cyc * 2 + 1); else log1.push_back(cyc * 2 + 1);
      end
    end
  endtask

  initial begin
    for (int i = 0; i < 2; i++) begin
      model_reset(i);
      for (int k = 0; k < 256; k++) ref_mem[i][k] = 16'h0000;
    end
    forever begin
      @(posedge clk);
      cyc = cyc + 1;
      model_step();
      #1;
      compare_all();
    end
  end

  // ---------------- directed stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // Waits for instance 0 to acknowledge A; lat = posedges from req to ack.
  task automatic wait_a_ack(output int lat);
    lat = 0;
    do begin
      @(posedge clk);
      #1;
      lat++;
    end while (a_ack_d[0] !== 1'b1 && lat < 20);
    if (a_ack_d[0] !== 1'b1) begin
      n_tests++;
      n_fail++;
      $display("FAIL a_ack_timeout dut0 cyc=%0d got=no ack expected=ack within 20 cycles", cyc);
    end
    #1;
  endtask

  task automatic check_order(input string nm, input int inst, input int start, input int n, input int ports [4]);
    int sz;
    sz = (inst == 0) ? log0.size() : log1.size();
    chk({nm, "_count"}, inst, 16'(sz - start >= n), 16'h1);
    if (sz - start >= n) begin
      for (int k = 0; k < n; k++) begin
        int e;
        e = (inst == 0) ? log0[start + k] : log1[start + k];
        chk({nm, "_port"}, inst, 16'(e % 2), 16'(ports[k]));
        if (k > 0) begin
          int p;
          p = (inst == 0) ? log0[start + k - 1] : log1[start + k - 1];
          chk({nm, "_spacing"}, inst, 16'(e / 2 - p / 2), 16'd3);
        end
      end
    end
  endtask

  initial begin
    int lat;
    int s0, s1;
    int ord_rr [4];
    int ord_fx [4];
    int ord_aa [4];

    rst = 1'b1;
    a_req = 1'b0; a_we = 1'b0; a_addr = 8'h00; a_wdata = 16'h0000;
    b_req = 1'b0; b_we = 1'b0; b_addr = 8'h00; b_wdata = 16'h0000;
    tick(3);
    for (int i = 0; i < 2; i++) begin
      chk("rst_busy",    i, 16'(busy_d[i]),  16'h0);
      chk("rst_a_ack",   i, 16'(a_ack_d[i]), 16'h0);
      chk("rst_a_rdata", i, a_rdata_d[i],    16'h0000);
      chk("rst_b_rdata", i, b_rdata_d[i],    16'h0000);
    end
    rst = 1'b0;
    tick(1);

    // A writes BEEF to 05, then reads it back
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h05; a_wdata = 16'hBEEF;
    wait_a_ack(lat);
    chk("wr_ack_latency", 0, 16'(lat), 16'd2);
    chk("wr_ack_dut1", 1, 16'(a_ack_d[1]), 16'h1);
    a_req = 1'b0; a_we = 1'b0;
    tick(1);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h05;
    wait_a_ack(lat);
    chk("rd_ack_latency", 0, 16'(lat), 16'd2);
    chk("rd_data", 0, a_rdata_d[0], 16'hBEEF);
    chk("rd_data", 1, a_rdata_d[1], 16'hBEEF);
    chk("mem_05", 0, g_dut[0].mem[8'h05], 16'hBEEF);
    a_req = 1'b0;
    tick(1);

    // Contention from reset release, both requests held continuously
    rst = 1'b1;
    tick(2);
    s0 = log0.size();
    s1 = log1.size();
    rst = 1'b0;
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h05;
    b_req = 1'b1; b_we = 1'b0; b_addr = 8'h05;
    tick(12);
    a_req = 1'b0; b_req = 1'b0;
    tick(2);
    ord_rr = '{0, 1, 0, 1};
    ord_fx = '{0, 0, 1, 0};
    check_order("rr_order", 0, s0, 4, ord_rr);
    check_order("fixed_order", 1, s1, 4, ord_fx);
    chk("rr_b_rdata", 0, b_rdata_d[0], 16'hBEEF);

    // A writes 0000 to FF so last grant is A, then B writes 1234 to FF
    // while A reads FF
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'hFF; a_wdata = 16'h0000;
    wait_a_ack(lat);
    a_req = 1'b0; a_we = 1'b0;
    tick(1);
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'hFF;
    b_req = 1'b1; b_we = 1'b1; b_addr = 8'hFF; b_wdata = 16'h1234;
    tick(6);
    a_req = 1'b0; b_req = 1'b0; b_we = 1'b0;
    tick(2);
    chk("ff_rdata_rr", 0, a_rdata_d[0], 16'h1234);
    chk("ff_rdata_fixed", 1, a_rdata_d[1], 16'h0000);
    chk("mem_ff", 0, g_dut[0].mem[8'hFF], 16'h1234);

    // Reset during a SERVE_A write of AAAA to 10
    s0 = log0.size();
    s1 = log1.size();
    a_req = 1'b1; a_we = 1'b1; a_addr = 8'h10; a_wdata = 16'hAAAA;
    tick(1);
    rst = 1'b1; a_req = 1'b0; a_we = 1'b0;
    tick(1);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      chk("rstmid_busy",  i, 16'(busy_d[i]),  16'h0);
      chk("rstmid_a_ack", i, 16'(a_ack_d[i]), 16'h0);
    end
    tick(3);
    chk("rstmid_mem_10", 0, g_dut[0].mem[8'h10], 16'h0000);
    chk("rstmid_mem_10", 1, g_dut[1].mem[8'h10], 16'h0000);
    chk("rstmid_no_ack", 0, 16'(log0.size() - s0), 16'd0);
    chk("rstmid_no_ack", 1, 16'(log1.size() - s1), 16'd0);

    // A holds its read request through several handshakes
    s0 = log0.size();
    a_req = 1'b1; a_we = 1'b0; a_addr = 8'h05;
    tick(8);
    a_req = 1'b0;
    tick(2);
    ord_aa = '{0, 0, 0, 0};
    check_order("held_req", 0, s0, 3, ord_aa);
    chk("held_req_total", 0, 16'(log0.size() - s0), 16'd3);
    chk("held_rdata", 0, a_rdata_d[0], 16'hBEEF);

    tick(2);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog cyc=%0d got=still running expected=finished", cyc);
    $fatal(1, "watchdog expired");
  end

endmodule
